input_shift_register: RTL and testbench

Input shift register (ISR) with shift counter, autopush and explicit PUSH handling for one state machine. It sits directly upstream of the RX FIFO: it shifts IN data into the ISR, then delivers completed 32-bit words to the RX FIFO's push port. While a blocked push is pending, it reports a stall to the instruction sequencer, which holds its program counter.

---
 rtl/input_shift_register.sv | 135 +++++++++++++
 tb/tb_input_shift_register.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/input_shift_register.sv
// Input shift register with shift counter, autopush and PUSH handling.
// Delivers completed words to the RX FIFO and stalls on blocked pushes.
module input_shift_register (
    input  logic        clk,
    input  logic        rst,
    input  logic        shift_en,
    input  logic [31:0] shift_data,
    input  logic [5:0]  shift_count,
    input  logic        shiftdir,
    input  logic        push_req,
    input  logic        push_iffull,
    input  logic        push_block,
    input  logic        autopush,
    input  logic [5:0]  push_thresh,
    input  logic        load_en,
    input  logic [31:0] load_data,
    input  logic        fifo_full,
    output logic        fifo_push_en,
    output logic [31:0] fifo_data,
    output logic [31:0] isr,
    output logic [5:0]  shift_counter,
    output logic        stall,
    output logic        dropped
);

    typedef enum logic {
        IDLE,
        PUSH_WAIT
    } state_t;

    state_t      state, state_n;
    logic [31:0] isr_n;
    logic [5:0]  cnt_n;
    logic        push_n;
    logic [31:0] data_n;
    logic        drop_n;

    logic [31:0] mask;
    logic [31:0] shifted;
    logic [6:0]  cnt_sum;
    logic [5:0]  cnt_sh;

    // Shift result and saturated count; a 32-bit shift moves the old
    // contents fully out, so n = 32 yields shift_data in both directions.
    always_comb begin
        mask    = (32'h1 << shift_count) - 32'h1;
        if (shiftdir)
            shifted = (isr >> shift_count) |
                      (shift_data << (6'd32 - shift_count));
        else
            shifted = (isr << shift_count) | (shift_data & mask);
        cnt_sum = {1'b0, shift_counter} + {1'b0, shift_count};
        cnt_sh  = (cnt_sum > 7'd32) ? 6'd32 : cnt_sum[5:0];
    end

    // Next-state and next-output decode for IDLE / PUSH_WAIT.
    always_comb begin
        state_n = state;
        isr_n   = isr;
        cnt_n   = shift_counter;
        push_n  = 1'b0;
        data_n  = fifo_data;
        drop_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (shift_en) begin
                    if (autopush && (cnt_sh >= push_thresh)) begin
                        if (!fifo_full) begin
                            push_n = 1'b1;
                            data_n = shifted;
                            isr_n  = '0;
                            cnt_n  = '0;
                        end else begin
                            isr_n   = shifted;
                            cnt_n   = cnt_sh;
                            state_n = PUSH_WAIT;
                        end
                    end else begin
                        isr_n = shifted;
                        cnt_n = cnt_sh;
                    end
                end else if (load_en) begin
                    isr_n = load_data;
                    cnt_n = '0;
                end else if (push_req &&
                             !(push_iffull && (shift_counter < push_thresh))) begin
                    if (!fifo_full) begin
                        push_n = 1'b1;
                        data_n = isr;
                        isr_n  = '0;
                        cnt_n  = '0;
                    end else if (push_block) begin
                        state_n = PUSH_WAIT;
                    end else begin
                        isr_n  = '0;
                        cnt_n  = '0;
                        drop_n = 1'b1;
                    end
                end
            end
            PUSH_WAIT: begin
                if (!fifo_full) begin
                    push_n  = 1'b1;
                    data_n  = isr;
                    isr_n   = '0;
                    cnt_n   = '0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs; reset discards any pending push.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            isr           <= '0;
            shift_counter <= '0;
            fifo_push_en  <= 1'b0;
            fifo_data     <= '0;
            stall         <= 1'b0;
            dropped       <= 1'b0;
        end else begin
            state         <= state_n;
            isr           <= isr_n;
            shift_counter <= cnt_n;
            fifo_push_en  <= push_n;
            fifo_data     <= data_n;
            stall         <= (state_n == PUSH_WAIT);
            dropped       <= drop_n;
        end
    end

endmodule

// File: tb/tb_input_shift_register.sv
// Directed bench for input_shift_register with a behavioural model
// compared every cycle plus literal expectations.
module tb_input_shift_register;

    logic        clk = 1'b0;
    logic        rst;
    logic        shift_en;
    logic [31:0] shift_data;
    logic [5:0]  shift_count;
    logic        shiftdir;
    logic        push_req;
    logic        push_iffull;
    logic        push_block;
    logic        autopush;
    logic [5:0]  push_thresh;
    logic        load_en;
    logic [31:0] load_data;
    logic        fifo_full;
    logic        fifo_push_en;
    logic [31:0] fifo_data;
    logic [31:0] isr;
    logic [5:0]  shift_counter;
    logic        stall;
    logic        dropped;

    input_shift_register dut (
        .clk(clk), .rst(rst),
        .shift_en(shift_en), .shift_data(shift_data),
        .shift_count(shift_count), .shiftdir(shiftdir),
        .push_req(push_req), .push_iffull(push_iffull),
        .push_block(push_block), .autopush(autopush),
        .push_thresh(push_thresh), .load_en(load_en),
        .load_data(load_data), .fifo_full(fifo_full),
        .fifo_push_en(fifo_push_en), .fifo_data(fifo_data),
        .isr(isr), .shift_counter(shift_counter),
        .stall(stall), .dropped(dropped)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_on = 0;
    int push_cnt = 0;

    // Model state, expressed in terms of the spec's rules
    logic [31:0] m_isr, m_data, nv;
    int          m_cnt, n, c2;
    bit          m_wait, m_push, m_drop;
    logic [63:0] t;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic emit(logic [31:0] w);
        m_push = 1; m_data = w; m_isr = '0; m_cnt = 0;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_isr = '0; m_cnt = 0; m_wait = 0;
            m_push = 0; m_data = '0; m_drop = 0;
        end else begin
            m_push = 0; m_drop = 0;
            if (m_wait) begin
                if (!fifo_full) begin emit(m_isr); m_wait = 0; end
            end else if (shift_en) begin
                n = int'(shift_count);
                if (shiftdir) begin
                    t  = {shift_data, m_isr} >> n;
                    nv = t[31:0];
                end else begin
                    t  = {m_isr, shift_data << (32 - n)} << n;
                    nv = t[63:32];
                end
                c2 = m_cnt + n;
                if (c2 > 32) c2 = 32;
                if (autopush && c2 >= int'(push_thresh)) begin
                    if (!fifo_full) emit(nv);
                    else begin m_isr = nv; m_cnt = c2; m_wait = 1; end
                end else begin
                    m_isr = nv; m_cnt = c2;
                end
            end else if (load_en) begin
                m_isr = load_data; m_cnt = 0;
            end else if (push_req) begin
                if (push_iffull && m_cnt < int'(push_thresh)) begin
                end else if (!fifo_full) emit(m_isr);
                else if (push_block) m_wait = 1;
                else begin m_isr = '0; m_cnt = 0; m_drop = 1; end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_on) begin
            chk("cyc_isr",   isr, m_isr);
            chk("cyc_cnt",   {26'b0, shift_counter}, m_cnt);
            chk("cyc_push",  {31'b0, fifo_push_en}, {31'b0, m_push});
            chk("cyc_data",  fifo_data, m_data);
            chk("cyc_stall", {31'b0, stall}, {31'b0, m_wait});
            chk("cyc_drop",  {31'b0, dropped}, {31'b0, m_drop});
            chk("cyc_excl",  {31'b0, fifo_push_en & dropped}, 32'd0);
            if (fifo_push_en) push_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle_in();
        shift_en = 0; shift_data = '0; shift_count = 6'd1; shiftdir = 0;
        push_req = 0; push_iffull = 0; push_block = 0; autopush = 0;
        push_thresh = 6'd32; load_en = 0; load_data = '0; fifo_full = 0;
    endtask

    task automatic do_reset();
        idle_in();
        rst = 1; tick(); rst = 0;
    endtask

    task automatic shl(logic d, logic [5:0] c, logic [31:0] v);
        shift_en = 1; shiftdir = d; shift_count = c; shift_data = v;
        tick();
        shift_en = 0;
    endtask

    task automatic lit(string nm, logic [31:0] i, int c,
                       logic p, logic s, logic dr);
        chk({nm, "_isr"},   isr, i);
        chk({nm, "_misr"},  m_isr, i);
        chk({nm, "_cnt"},   {26'b0, shift_counter}, c);
        chk({nm, "_mcnt"},  m_cnt, c);
        chk({nm, "_push"},  {31'b0, fifo_push_en}, {31'b0, p});
        chk({nm, "_stall"}, {31'b0, stall}, {31'b0, s});
        chk({nm, "_drop"},  {31'b0, dropped}, {31'b0, dr});
    endtask

    int pc0;

    initial begin
        idle_in();
        rst = 1; tick(); tick();
        chk_on = 1;
        rst = 0;
        lit("reset", 32'h0, 0, 0, 0, 0);
        chk("reset_data", fifo_data, 32'h0);

        // Left shift three bytes, no autopush
        pc0 = push_cnt;
        shl(0, 6'd8, 32'hAB); shl(0, 6'd8, 32'hAB); shl(0, 6'd8, 32'hAB);
        lit("left", 32'h00ABABAB, 24, 0, 0, 0);
        chk("left_nopush", push_cnt - pc0, 0);

        // Right shift, then full-width shift with saturation
        do_reset();
        shl(1, 6'd4, 32'hF);
        lit("right4", 32'hF0000000, 4, 0, 0, 0);
        shl(1, 6'd32, 32'hDEADBEEF);
        lit("right32", 32'hDEADBEEF, 32, 0, 0, 0);

        // Autopush with FIFO free
        do_reset();
        autopush = 1; push_thresh = 6'd16;
        shl(0, 6'd8, 32'h12);
        lit("ap1", 32'h12, 8, 0, 0, 0);
        shl(0, 6'd8, 32'h34);
        lit("ap2", 32'h0, 0, 1, 0, 0);
        chk("ap2_data", fifo_data, 32'h00001234);
        tick();
        chk("ap_hold_data", fifo_data, 32'h00001234);
        chk("ap_pulse", {31'b0, fifo_push_en}, 32'd0);

        // Autopush with FIFO full, requests ignored while waiting
        do_reset();
        autopush = 1; push_thresh = 6'd16; fifo_full = 1;
        shl(0, 6'd8, 32'h12);
        shl(0, 6'd8, 32'h34);
        lit("apf", 32'h00001234, 16, 0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            shift_en = k[0]; shift_data = 32'hFFFF_FFFF; shift_count = 6'd8;
            push_req = 1; load_en = 1; load_data = 32'h1;
            tick();
            lit("apf_hold", 32'h00001234, 16, 0, 1, 0);
        end
        idle_in(); autopush = 1; push_thresh = 6'd16;
        tick();
        lit("apf_rel", 32'h0, 0, 1, 0, 0);
        chk("apf_rel_data", fifo_data, 32'h00001234);

        // Back-to-back autopush every cycle at n = 32
        do_reset();
        autopush = 1; push_thresh = 6'd32;
        pc0 = push_cnt;
        shl(0, 6'd32, 32'h11111111);
        chk("b2b_d1", fifo_data, 32'h11111111);
        shift_en = 1; shift_data = 32'h22222222; shift_count = 6'd32;
        tick();
        chk("b2b_d2", fifo_data, 32'h22222222);
        shift_data = 32'h33333333;
        tick();
        shift_en = 0;
        chk("b2b_d3", fifo_data, 32'h33333333);
        chk("b2b_count", push_cnt - pc0, 3);

        // PUSH variants
        do_reset();
        shl(0, 6'd8, 32'h77);
        push_req = 1; push_iffull = 1; push_thresh = 6'd16;
        tick();
        lit("iffull_noop", 32'h77, 8, 0, 0, 0);
        push_iffull = 0; push_block = 0; fifo_full = 1;
        tick();
        lit("drop", 32'h0, 0, 0, 0, 1);
        idle_in();
        tick();
        lit("drop_pulse", 32'h0, 0, 0, 0, 0);
        load_en = 1; load_data = 32'h5A5A5A5A;
        tick();
        lit("load", 32'h5A5A5A5A, 0, 0, 0, 0);
        idle_in(); push_req = 1;
        tick();
        lit("push", 32'h0, 0, 1, 0, 0);
        chk("push_data", fifo_data, 32'h5A5A5A5A);

        // Reset while a blocked push is pending
        idle_in(); load_en = 1; load_data = 32'h11;
        tick();
        idle_in(); push_req = 1; push_block = 1; fifo_full = 1;
        tick();
        lit("blk", 32'h11, 0, 0, 1, 0);
        idle_in(); fifo_full = 1;
        tick();
        lit("blk_hold", 32'h11, 0, 0, 1, 0);
        rst = 1;
        tick();
        rst = 0;
        lit("rst_wait", 32'h0, 0, 0, 0, 0);
        chk("rst_wait_data", fifo_data, 32'h0);
        pc0 = push_cnt;
        fifo_full = 0;
        tick(); tick(); tick();
        chk("rst_nopush", push_cnt - pc0, 0);

        chk_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
